// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
// Each instruction is decoded as it is accepted and held in a main register,
// with a one-entry skid register behind it so that in_ready can be a flop
// and the stage still sustains one instruction per cycle.
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = $clog2(DATA_WIDTH),
  parameter int unsigned ILL_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [2:0]            alu_op,
  output logic [2:0]            imm_op,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  illegal,
  output logic [ILL_CNT_W-1:0]  ill_count
);

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] ALU_MEM   = 3'b000;
  localparam logic [2:0] ALU_REG   = 3'b001;
  localparam logic [2:0] ALU_IMM   = 3'b010;
  localparam logic [2:0] ALU_BR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_AUIPC = 3'b101;
  localparam logic [2:0] ALU_JAL   = 3'b110;
  localparam logic [2:0] ALU_NONE  = 3'b111;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  // One decoded instruction as it travels through the stage
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [2:0]            alu_op;
    logic [2:0]            imm_op;
    logic [DATA_WIDTH-1:0] imm;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  illegal;
  } entry_t;

  entry_t                r_main;
  entry_t                r_skid;
  logic                  r_main_valid;
  logic                  r_skid_valid;
  logic [ILL_CNT_W-1:0]  r_ill_count;

  entry_t                w_dec;
  logic [INSTR_W-1:0]    w_word;
  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [INSTR_W-1:0]    w_imm_i;
  logic [INSTR_W-1:0]    w_imm_s;
  logic [INSTR_W-1:0]    w_imm_b;
  logic [INSTR_W-1:0]    w_imm_u;
  logic [INSTR_W-1:0]    w_imm_j;
  logic                  w_accept;
  logic                  w_deliver;

  assign w_accept  = in_valid && !r_skid_valid;
  assign w_deliver = r_main_valid && out_ready;

  // Instruction fields and the five immediate formats
  always_comb begin
    w_word   = INSTR_W'(in_instr);
    w_opcode = w_word[6:0];
    w_funct3 = w_word[14:12];
    w_rs1    = REG_ADDR_W'(w_word[19:15]);
    w_rs2    = REG_ADDR_W'(w_word[24:20]);
    w_rd     = REG_ADDR_W'(w_word[11:7]);
    w_imm_i  = {{20{w_word[31]}}, w_word[31:20]};
    w_imm_s  = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
    w_imm_b  = {{19{w_word[31]}}, w_word[31], w_word[7], w_word[30:25],
                w_word[11:8], 1'b0};
    w_imm_u  = {w_word[31:12], 12'b0};
    w_imm_j  = {{11{w_word[31]}}, w_word[31], w_word[19:12], w_word[20],
                w_word[30:21], 1'b0};
  end

  // Decode table; anything not matched stays illegal with all fields cleared
  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.alu_op  = ALU_NONE;
    w_dec.imm_op  = IMM_NONE;
    w_dec.illegal = 1'b1;
    case (w_opcode)
      OPC_LOAD: begin
        if (w_funct3 == F3_WORD) begin
          w_dec.alu_op    = ALU_MEM;
          w_dec.imm_op    = IMM_I;
          w_dec.imm       = DATA_WIDTH'(w_imm_i);
          w_dec.reg_write = 1'b1;
          w_dec.mem_read  = 1'b1;
          w_dec.rs1       = w_rs1;
          w_dec.rd        = w_rd;
          w_dec.illegal   = 1'b0;
        end
      end
      OPC_STORE: begin
        if (w_funct3 == F3_WORD) begin
          w_dec.alu_op    = ALU_MEM;
          w_dec.imm_op    = IMM_S;
          w_dec.imm       = DATA_WIDTH'(w_imm_s);
          w_dec.mem_write = 1'b1;
          w_dec.rs1       = w_rs1;
          w_dec.rs2       = w_rs2;
          w_dec.illegal   = 1'b0;
        end
      end
      OPC_OP: begin
        w_dec.alu_op    = ALU_REG;
        w_dec.imm_op    = IMM_NONE;
        w_dec.reg_write = 1'b1;
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.rd        = w_rd;
        w_dec.illegal   = 1'b0;
      end
      OPC_OPIMM: begin
        w_dec.alu_op    = ALU_IMM;
        w_dec.imm_op    = IMM_I;
        w_dec.imm       = DATA_WIDTH'(w_imm_i);
        w_dec.reg_write = 1'b1;
        w_dec.rs1       = w_rs1;
        w_dec.rd        = w_rd;
        w_dec.illegal   = 1'b0;
      end
      OPC_BRANCH: begin
        w_dec.alu_op  = ALU_BR;
        w_dec.imm_op  = IMM_B;
        w_dec.imm     = DATA_WIDTH'(w_imm_b);
        w_dec.rs1     = w_rs1;
        w_dec.rs2     = w_rs2;
        w_dec.illegal = 1'b0;
      end
      OPC_LUI: begin
        w_dec.alu_op    = ALU_LUI;
        w_dec.imm_op    = IMM_U;
        w_dec.imm       = DATA_WIDTH'(w_imm_u);
        w_dec.reg_write = 1'b1;
        w_dec.rd        = w_rd;
        w_dec.illegal   = 1'b0;
      end
      OPC_AUIPC: begin
        w_dec.alu_op    = ALU_AUIPC;
        w_dec.imm_op    = IMM_U;
        w_dec.imm       = DATA_WIDTH'(w_imm_u);
        w_dec.reg_write = 1'b1;
        w_dec.rd        = w_rd;
        w_dec.illegal   = 1'b0;
      end
      OPC_JAL: begin
        w_dec.alu_op    = ALU_JAL;
        w_dec.imm_op    = IMM_J;
        w_dec.imm       = DATA_WIDTH'(w_imm_j);
        w_dec.reg_write = 1'b1;
        w_dec.rd        = w_rd;
        w_dec.illegal   = 1'b0;
      end
      default: ;
    endcase
  end

  // Main/skid buffer: the main register only changes on delivery or when it
  // is empty, so outputs hold steady while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main        <= '0;
      r_main.alu_op <= ALU_NONE;
      r_main.imm_op <= IMM_NONE;
      r_skid        <= '0;
      r_main_valid  <= 1'b0;
      r_skid_valid  <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_deliver) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main <= w_dec;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (r_main_valid) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
      end else begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end
    end
  end

  // Saturating count of illegal entries handed downstream; flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_count <= '0;
    end else if (w_deliver && r_main.illegal && !(&r_ill_count)) begin
      r_ill_count <= r_ill_count + ILL_CNT_W'(1);
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_pc    = r_main.pc;
  assign alu_op    = r_main.alu_op;
  assign imm_op    = r_main.imm_op;
  assign imm       = r_main.imm;
  assign mem_read  = r_main.mem_read;
  assign mem_write = r_main.mem_write;
  assign reg_write = r_main.reg_write;
  assign rs1       = r_main.rs1;
  assign rs2       = r_main.rs2;
  assign rd        = r_main.rd;
  assign illegal   = r_main.illegal;
  assign ill_count = r_ill_count;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Expected decodes come
// from a hand-written vector table; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, mem_read, mem_write, reg_write, illegal;
  logic [31:0] out_pc, imm;
  logic [2:0]  alu_op, imm_op;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] ill_count;

  logic        s_in_ready, s_out_valid, s_mem_read, s_mem_write, s_reg_write, s_illegal;
  logic [31:0] s_out_pc, s_imm;
  logic [2:0]  s_alu_op, s_imm_op;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [1:0]  s_ill_count;

  decode_stage u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .alu_op(alu_op), .imm_op(imm_op), .imm(imm), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal(illegal), .ill_count(ill_count)
  );

  decode_stage #(.ILL_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .alu_op(s_alu_op), .imm_op(s_imm_op), .imm(s_imm),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .reg_write(s_reg_write),
    .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .illegal(s_illegal), .ill_count(s_ill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  alu;
    logic [2:0]  iop;
    logic [31:0] imm;
    logic        mr, mw, rw;
    logic [4:0]  rs1, rs2, rd;
    logic        ill;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
  } exp_t;

  localparam int NVEC = 14;
  vec_t        vecs[NVEC];
  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt;
  logic [1:0]  exp_cnt2;

  function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] alu,
                              input logic [2:0] iop, input logic [31:0] im,
                              input logic mr, input logic mw, input logic rw,
                              input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic ill);
    vec_t v;
    v.instr = instr; v.alu = alu; v.iop = iop; v.imm = im;
    v.mr = mr; v.mw = mw; v.rw = rw; v.rs1 = a; v.rs2 = b; v.rd = d; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_pc",    out_pc,         32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'd7);
    chk("rst_imm_op",    32'(imm_op),    32'd7);
    chk("rst_imm",       imm,            32'd0);
    chk("rst_ctrl",      32'({mem_read, mem_write, reg_write}), 32'd0);
    chk("rst_regs",      32'({rs1, rs2, rd}), 32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    chk("rst_ill_count", 32'(ill_count), 32'd0);
    chk("rst_ill_sat",   32'(s_ill_count), 32'd0);
  endtask

  // One clock of stimulus: check the state left by the last edge, then drive
  // the inputs for the next edge and advance the scoreboard accordingly
  task automatic step(input logic v, input int idx, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    exp_t e;
    vec_t x;
    logic acc, del;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
    chk("in_ready",  32'(in_ready),  32'(sbq.size() < 2));
    chk("ill_count", 32'(ill_count), exp_cnt);
    chk("ill_sat",   32'(s_ill_count), 32'(exp_cnt2));
    if (sbq.size() != 0) begin
      e = sbq[0];
      x = vecs[e.idx];
      chk("out_pc",    out_pc,            e.pc);
      chk("alu_op",    32'(alu_op),       32'(x.alu));
      chk("imm_op",    32'(imm_op),       32'(x.iop));
      chk("imm",       imm,               x.imm);
      chk("mem_read",  32'(mem_read),     32'(x.mr));
      chk("mem_write", 32'(mem_write),    32'(x.mw));
      chk("reg_write", 32'(reg_write),    32'(x.rw));
      chk("rs1",       32'(rs1),          32'(x.rs1));
      chk("rs2",       32'(rs2),          32'(x.rs2));
      chk("rd",        32'(rd),           32'(x.rd));
      chk("illegal",   32'(illegal),      32'(x.ill));
    end
    in_valid  = v;
    in_instr  = vecs[idx].instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && in_ready;
    del = out_valid && ordy;
    if (del && sbq.size() != 0) begin
      if (vecs[sbq[0].idx].ill) begin
        exp_cnt = exp_cnt + 32'd1;
        if (exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 2'd1;
      end
      void'(sbq.pop_front());
    end
    if (fl) begin
      sbq.delete();
    end else if (acc) begin
      e.idx = idx;
      e.pc  = pc;
      sbq.push_back(e);
    end
  endtask

  initial begin
    vecs[0]  = mk(32'h000AAA83, 3'b000, 3'b000, 32'h00000000, 1, 0, 1, 21, 0, 21, 0); // lw x21,0(x21)
    vecs[1]  = mk(32'hFFFFFFFF, 3'b111, 3'b111, 32'h00000000, 0, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(32'h00532423, 3'b000, 3'b001, 32'h00000008, 0, 1, 0, 6, 5, 0, 0);   // sw x5,8(x6)
    vecs[3]  = mk(32'hFE208EE3, 3'b011, 3'b010, 32'hFFFFFFFC, 0, 0, 0, 1, 2, 0, 0);   // beq x1,x2,-4
    vecs[4]  = mk(32'h002081B3, 3'b001, 3'b111, 32'h00000000, 0, 0, 1, 1, 2, 3, 0);   // add x3,x1,x2
    vecs[5]  = mk(32'hFFF00293, 3'b010, 3'b000, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 5, 0);   // addi x5,x0,-1
    vecs[6]  = mk(32'h123453B7, 3'b100, 3'b011, 32'h12345000, 0, 0, 1, 0, 0, 7, 0);   // lui x7
    vecs[7]  = mk(32'hFFFFF417, 3'b101, 3'b011, 32'hFFFFF000, 0, 0, 1, 0, 0, 8, 0);   // auipc x8
    vecs[8]  = mk(32'hFF9FF0EF, 3'b110, 3'b100, 32'hFFFFFFF8, 0, 0, 1, 0, 0, 1, 0);   // jal x1,-8
    vecs[9]  = mk(32'h00008083, 3'b111, 3'b111, 32'h00000000, 0, 0, 0, 0, 0, 0, 1);   // lb: illegal
    vecs[10] = mk(32'h00001023, 3'b111, 3'b111, 32'h00000000, 0, 0, 0, 0, 0, 0, 1);   // sh: illegal
    vecs[11] = mk(32'h0000000F, 3'b111, 3'b111, 32'h00000000, 0, 0, 0, 0, 0, 0, 1);   // fence: illegal
    vecs[12] = mk(32'hFFC1A103, 3'b000, 3'b000, 32'hFFFFFFFC, 1, 0, 1, 3, 0, 2, 0);   // lw x2,-4(x3)
    vecs[13] = mk(32'hFE532C23, 3'b000, 3'b001, 32'hFFFFFFF8, 0, 1, 0, 6, 5, 0, 0);   // sw x5,-8(x6)

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; exp_cnt = '0; exp_cnt2 = '0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;

    // single load, then an illegal word, then store and branch back to back
    step(1, 0, 32'h100, 1, 0);
    step(0, 0, 32'h0,   1, 0);
    step(1, 1, 32'h104, 1, 0);
    step(0, 0, 32'h0,   1, 0);
    step(1, 2, 32'h108, 1, 0);
    step(1, 3, 32'h10C, 1, 0);
    step(0, 0, 32'h0,   1, 0);
    step(0, 0, 32'h0,   1, 0);

    // full-rate stream through every vector
    for (int i = 0; i < NVEC; i++) step(1, i, 32'h200 + 32'(i * 4), 1, 0);
    repeat (2) step(0, 0, 32'h0, 1, 0);

    // downstream stalled, three offers: main then skid fill, third is refused
    step(1, 4, 32'h300, 0, 0);
    step(1, 5, 32'h304, 0, 0);
    step(1, 6, 32'h308, 0, 0);
    step(0, 0, 32'h0,   0, 0);
    repeat (3) step(0, 0, 32'h0, 1, 0);

    // flush with both entries full and a new offer, nothing delivered
    step(1, 1, 32'h400, 0, 0);
    step(1, 9, 32'h404, 0, 0);
    step(1, 7, 32'h408, 0, 1);
    step(0, 0, 32'h0,   0, 0);
    // flush in the same cycle as delivery of an illegal entry
    step(1, 10, 32'h410, 0, 0);
    step(1, 11, 32'h414, 0, 0);
    step(1, 8,  32'h418, 1, 1);
    step(0, 0,  32'h0,   1, 0);

    // randomised traffic with occasional stalls and flushes
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, int'($urandom_range(NVEC - 1, 0)), $urandom,
           ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    repeat (3) step(0, 0, 32'h0, 1, 0);

    // asynchronous reset with both entries occupied
    step(1, 1, 32'h500, 0, 0);
    step(1, 2, 32'h504, 0, 0);
    step(0, 0, 32'h0,   0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset();
    sbq.delete();
    exp_cnt  = '0;
    exp_cnt2 = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // five illegal words: wide counter reaches 5, 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) step(1, (i % 2) ? 11 : 1, 32'h600 + 32'(i * 4), 1, 0);
    repeat (3) step(0, 0, 32'h0, 1, 0);
    chk("ill_final", 32'(ill_count), 32'd5);
    chk("ill_sat_final", 32'(s_ill_count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
